// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel front end: pixel and operand widths,
// the window-generator FSM state type and a counter-width helper.
package sobel_pkg;
    localparam int PIX_W = 8;
    localparam int WIN_W = 9;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } sobel_win_state_t;

    // Width of a counter covering 0..n-1; never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sobel_line_buf.sv
// One image row of pixels. Read-before-write single-port memory: the read port
// returns the old contents at addr while the same cycle's write lands at the edge.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);
    logic [PIX_W-1:0] mem [DEPTH];

    // addr is driven straight from a register in the parent, so the read path
    // starts at a flop and the old word is available alongside the write.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
    end

    assign dout = mem[addr];
endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator feeding the sobel operator; two line buffers,
// a 3x3 shift register and a registered output window. Option: SOBEL_WIN_SOF_EN.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
`ifdef SOBEL_WIN_SOF_EN
    input  logic             pix_sof,
`endif
    output logic             pix_ready,
    output logic [WIN_W-1:0] win0,
    output logic [WIN_W-1:0] win1,
    output logic [WIN_W-1:0] win2,
    output logic [WIN_W-1:0] win3,
    output logic [WIN_W-1:0] win4,
    output logic [WIN_W-1:0] win5,
    output logic [WIN_W-1:0] win6,
    output logic [WIN_W-1:0] win7,
    output logic [WIN_W-1:0] win8,
    output logic             win_valid,
    input  logic             win_ready
);
    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] pos_col;
    logic [RW-1:0] pos_row;
    logic          accept, sof, emit;
    logic [PIX_W-1:0] lb0_q, lb1_q;
    logic [2:0][2:0][PIX_W-1:0] sr, sr_nxt;
    logic [8:0][PIX_W-1:0] wpix;
    sobel_win_state_t state_q, state_d;

`ifdef SOBEL_WIN_SOF_EN
    assign sof = pix_sof;
`else
    assign sof = 1'b0;
`endif

    assign pix_ready = !rst && (!win_valid || win_ready);
    assign accept    = pix_valid && pix_ready;

    // Position of the pixel being accepted; a start-of-frame pixel is (0,0).
    assign pos_col = sof ? '0 : col;
    assign pos_row = sof ? '0 : row;

    sobel_line_buf #(.DEPTH(IMG_W), .AW(CW)) u_lb0 (
        .clk(clk), .we(accept), .addr(pos_col), .din(pix_in), .dout(lb0_q)
    );
    sobel_line_buf #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
        .clk(clk), .we(accept), .addr(pos_col), .din(lb0_q), .dout(lb1_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (pos_col == COL_LAST) begin
                col <= '0;
                row <= (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
            end else begin
                col <= pos_col + 1'b1;
                row <= pos_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_FILL;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (sof) begin
                state_d = ST_FILL;
            end else if (state_q == ST_FILL) begin
                if (pos_row == RW'(1) && pos_col == COL_LAST) state_d = ST_RUN;
            end else begin
                if (pos_row == ROW_LAST && pos_col == COL_LAST) state_d = ST_FILL;
            end
        end
    end

    always_comb begin
        emit = accept && (state_q == ST_RUN) && (pos_col >= COL_TWO);
    end

    // Row 0 = oldest line (lb1), row 2 = incoming line; column 2 = newest.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            sr_nxt[r][0] = sr[r][1];
            sr_nxt[r][1] = sr[r][2];
        end
        sr_nxt[0][2] = lb1_q;
        sr_nxt[1][2] = lb0_q;
        sr_nxt[2][2] = pix_in;
    end

    always_ff @(posedge clk) begin
        if (accept) sr <= sr_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid <= 1'b0;
            wpix      <= '0;
        end else if (emit) begin
            win_valid <= 1'b1;
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++)
                    wpix[3*r+k] <= sr_nxt[r][k];
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

    assign win0 = {1'b0, wpix[0]};
    assign win1 = {1'b0, wpix[1]};
    assign win2 = {1'b0, wpix[2]};
    assign win3 = {1'b0, wpix[3]};
    assign win4 = {1'b0, wpix[4]};
    assign win5 = {1'b0, wpix[5]};
    assign win6 = {1'b0, wpix[6]};
    assign win7 = {1'b0, wpix[7]};
    assign win8 = {1'b0, wpix[8]};
endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 3x3 window generator that sits directly upstream of the combinational `sobel` operator. It accepts one 8-bit raster-order pixel per handshake and buffers the two previous image rows in line memories. Once a full neighbourhood exists, it presents the nine pixels as a registered 3x3 window, zero-extended to 9 bits, on the `sobel` operand inputs `in0`..`in8`. It produces one window per interior pixel, with valid/ready flow control on both sides.

## Interface
Parameters:
- `IMG_W`, 64, image width in pixels (≥3)
- `IMG_H`, 64, image height in lines (≥3)

Ports:
- `clk` in 1: sole clock; all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `pix_in` in 8: input pixel, raster order, row-major
- `pix_valid` in 1: `pix_in` valid
- `pix_ready` out 1: block can accept `pix_in` this cycle
- `win0`..`win8` out 9 each: window, row-major; `win0`=top-left, `win4`=centre, `win8`=bottom-right; bit 8 always 0
- `win_valid` out 1: window outputs valid
- `win_ready` in 1: downstream accepts window

## Operation
- Accept: a pixel is accepted when `pix_valid && pix_ready`. `pix_ready = !rst && (!win_valid || win_ready)`.
- Counters: `col` in 0..IMG_W-1 and `row` in 0..IMG_H-1 mark the position of the next pixel.
  - Both advance only on accept.
  - `col` wraps to 0 at IMG_W-1 and `row` increments.
  - After (IMG_H-1, IMG_W-1), both wrap to 0 (next frame).
- Line buffers `lb0` and `lb1`, depth IMG_W:
  - On accept at column c, read-before-write: `lb1[c]` receives the old `lb0[c]`, and `lb0[c]` receives `pix_in`.
  - `lb0` holds row r-1 and `lb1` holds row r-2.
- Window shift register: 3 rows x 3 columns of 8 bits. On accept it shifts left one column and loads the new right column {`lb1[c]`, `lb0[c]`, `pix_in`}.
- FSM (`ST_FILL`, `ST_RUN`):
  - `ST_FILL` while row<2. Transition to `ST_RUN` on accept of (1, IMG_W-1).
  - `ST_RUN` while row≥2. Transition to `ST_FILL` on accept of (IMG_H-1, IMG_W-1).
- Emit: in `ST_RUN`, an accept with col≥2 loads the outputs from the updated shift register and sets `win_valid`. The window is centred at (row-1, col-1).
- Window count: (IMG_W-2)·(IMG_H-2) windows per frame. Accepts with col<2 emit nothing, so there is no cross-line window.
- Clear: `win_valid` clears on `win_ready` when no new window is loaded the same cycle.
- Simultaneous `win_ready` and an emitting accept: new window loaded, `win_valid` stays 1.
- Stall: `win*` are held stable while `win_valid && !win_ready`.
- Arithmetic: `winN = {1'b0, pixel}`. No other arithmetic.

## Timing
- Latency: 1 cycle. A window is visible on the cycle after the accept that completes it.
- Throughput: one pixel and one window per cycle with `win_ready` held high.
- Reset values: `win_valid`=0, `win0`..`win8`=0, `pix_ready`=0 during `rst`, row=col=0, FSM=`ST_FILL`.
  - Line-buffer contents are not reset; they are overwritten before use.
- Reset mid-frame: in-flight window discarded; the next accepted pixel is (0,0).
- No pixel is dropped or duplicated under any `pix_valid`/`win_ready` pattern.

## Configuration
- `SOBEL_WIN_SOF_EN` defined:
  - Adds input `pix_sof` (1 bit).
  - An accepted pixel with `pix_sof`=1 is forced to position (0,0). Counters restart from there and the FSM goes to `ST_FILL`.
  - A pending output window is unaffected.
- Undefined: no `pix_sof` port; frame boundaries come purely from the IMG_W·IMG_H count.

## Structure
- Shared package `sobel_pkg`:
  - `PIX_W`=8 and `WIN_W`=9.
  - State typedef `sobel_win_state_t` {`ST_FILL`, `ST_RUN`}.
  - Function computing `$clog2` widths for the counters.
- One sub-module `sobel_line_buf`: depth IMG_W, 8-bit, read-before-write single-port memory with registered address input. Instantiated twice.
- FSM, counters, shift register and output register live in the top block.

## Test plan
All cases use IMG_W=4, IMG_H=4, pixel(r,c)=16r+c, `win_ready`=1 unless stated.
- Nominal frame: 16 pixels back-to-back -> exactly 4 windows.
  - First window `win0`..`win8` = 0,1,2,16,17,18,32,33,34, one cycle after accepting pixel 34.
  - Last window `win0`..`win8` = 17,18,19,33,34,35,49,50,51.
- Backpressure: `win_ready`=0 after the first window -> `pix_ready`=0 and window held stable for 5 cycles. Release -> the remaining 3 windows arrive in order with correct values.
- Bubbles: `pix_valid` toggled every other cycle -> same 4 windows; `win_valid` never asserted without a completing accept.
- Two frames back-to-back (second frame pixel+100) -> 4 windows each. The second frame's first window is 100,101,102,116,117,118,132,133,134, with no window straddling the frames.
- Reset mid-frame: `rst` after 7 accepts -> `win_valid`=0 next cycle. A fresh full frame then yields the nominal 4 windows.
- With `SOBEL_WIN_SOF_EN` defined: `pix_sof` asserted on the 6th pixel -> that pixel is treated as (0,0). Exactly 4 windows follow over the next 16 pixels.
